// File: rtl/readout_addr_pattern_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : readout_pkg
// Purpose : Shared widths, LFSR tap mask and TDC word layout for the
//           readout address / test-pattern block.
// Rev     : 1.0  initial release
// ============================================================================
package readout_pkg;

  localparam int unsigned c_CB_AW  = 9;
  localparam int unsigned c_L1_AW  = 7;

  localparam int unsigned c_TOA_W  = 10;
  localparam int unsigned c_TOT_W  = 9;
  localparam int unsigned c_CAL_W  = 10;
  localparam int unsigned c_TDC_W  = c_TOA_W + c_TOT_W + c_CAL_W + 1;

  // Taps 32,22,2,1 expressed as a mask over bit indices 31,21,1,0
  localparam logic [31:0] c_LFSR_TAPS = 32'h8020_0003;

  typedef struct packed {
    logic [c_TOA_W-1:0] toa;
    logic [c_TOT_W-1:0] tot;
    logic [c_CAL_W-1:0] cal;
    logic               hit;
  } tdc_word_t;

  // One Fibonacci step: shift left, XOR of tapped bits enters at bit 0
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {s[30:0], ^(s & c_LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/readout_addr_pattern_gen_if.sv
`default_nettype none
// ============================================================================
// Module  : readout_addr_pattern_gen_if
// Purpose : L1-buffer request/status bundle between the readout core
//           (master) and the address manager (slave).
// Rev     : 1.0  initial release
// ============================================================================
interface readout_addr_pattern_gen_if
  import readout_pkg::*;
#(
  parameter int unsigned L1_AW = c_L1_AW
) ();

  logic             l1_wr_en;
  logic             l1_rd_en;
  logic [L1_AW-1:0] l1_word_cnt;
  logic [L1_AW-1:0] l1_wr_addr;
  logic [L1_AW-1:0] l1_rd_addr;
  logic             l1_empty;
  logic             l1_full;
  logic             l1_first_evt;

  modport master (
    output l1_wr_en, l1_rd_en,
    input  l1_word_cnt, l1_wr_addr, l1_rd_addr, l1_empty, l1_full, l1_first_evt
  );

  modport slave (
    input  l1_wr_en, l1_rd_en,
    output l1_word_cnt, l1_wr_addr, l1_rd_addr, l1_empty, l1_full, l1_first_evt
  );

endinterface
`default_nettype wire

// File: rtl/readout_addr_pattern_gen_tdc_pattern_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : tdc_pattern_lfsr
// Purpose : Pseudo-random / counting TDC stimulus generator. Produces one
//           registered TDC word per cycle, gated by an occupancy threshold.
// Rev     : 1.0  initial release
// ============================================================================
module tdc_pattern_lfsr
  import readout_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_dis,
  input  logic      i_mode,
  input  logic [8:0] i_latency_l1a,
  input  logic [7:0] i_pixel_id,
  input  logic [6:0] i_occupancy,
  output tdc_word_t o_tdc_word
);

  logic [31:0]        r_lfsr;
  logic [c_TOA_W-1:0] r_cnt;
  tdc_word_t          r_word;
  tdc_word_t          w_word;
  logic               w_hit;

  // Build the candidate word from current state; a miss yields all zeros
  always_comb begin
    w_word = '0;
    w_hit  = (r_lfsr[6:0] < i_occupancy);
    if (w_hit) begin
      w_word.hit = 1'b1;
      if (i_mode) begin
        w_word.toa = r_lfsr[31:22];
        w_word.tot = r_lfsr[21:13];
        w_word.cal = r_lfsr[16:7];
      end else begin
        w_word.toa = r_cnt;
        w_word.tot = r_cnt[c_TOT_W-1:0];
        w_word.cal = {i_pixel_id, 2'b00};
      end
    end
  end

  // Seed is pixel/latency dependent and always has bit 0 set, so never zero;
  // disable freezes both LFSR and counter so the sequence resumes intact
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= {i_pixel_id, 6'b0, i_latency_l1a, 9'h001};
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_dis) begin
      r_word <= '0;
    end else begin
      r_word <= w_word;
      r_lfsr <= lfsr_step(r_lfsr);
      r_cnt  <= r_cnt + c_TOA_W'(1);
    end
  end

  assign o_tdc_word = r_word;

endmodule
`default_nettype wire

// File: rtl/readout_addr_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : readout_addr_pattern_gen
// Purpose : Circular-buffer write counter, L1 FIFO address/occupancy manager
//           and TDC test-pattern generator for the pixel readout core.
// Rev     : 1.0  initial release
// ============================================================================
module readout_addr_pattern_gen
  import readout_pkg::*;
#(
  parameter int unsigned CB_AW = c_CB_AW,
  parameter int unsigned L1_AW = c_L1_AW
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [CB_AW-1:0]         cb_wr_addr,
  readout_addr_pattern_gen_if.slave l1,
  input  logic                     tdc_dis,
  input  logic                     tdc_mode,
  input  logic [8:0]               latency_l1a,
  input  logic [7:0]               pixel_id,
  input  logic [6:0]               occupancy,
  output logic [c_TDC_W-1:0]       tdc_data
);

  // One slot is sacrificed so that count and pointers share the same width
  localparam logic [L1_AW-1:0] c_L1_FULL_CNT = {L1_AW{1'b1}};

  logic [CB_AW-1:0] r_cb_addr;
  logic [L1_AW-1:0] r_wr_addr;
  logic [L1_AW-1:0] r_rd_addr;
  logic [L1_AW-1:0] r_word_cnt;
  logic             r_first_evt;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  tdc_word_t        w_tdc_word;

  // Free-running circular-buffer write address, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) r_cb_addr <= '0;
    else       r_cb_addr <= r_cb_addr + CB_AW'(1);
  end

  assign w_empty = (r_word_cnt == '0);
  assign w_full  = (r_word_cnt == c_L1_FULL_CNT);
  assign w_push  = l1.l1_wr_en && !w_full;
  assign w_pop   = l1.l1_rd_en && !w_empty;

  // L1 pointers and occupancy; a push into a full buffer is dropped even
  // when a pop happens the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
      r_word_cnt  <= '0;
      r_first_evt <= 1'b0;
    end else begin
      if (w_push) r_wr_addr <= r_wr_addr + L1_AW'(1);
      if (w_pop)  r_rd_addr <= r_rd_addr + L1_AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_word_cnt <= r_word_cnt + L1_AW'(1);
        2'b01:   r_word_cnt <= r_word_cnt - L1_AW'(1);
        default: r_word_cnt <= r_word_cnt;
      endcase
      r_first_evt <= w_push && w_empty;
    end
  end

  assign cb_wr_addr      = r_cb_addr;
  assign l1.l1_word_cnt  = r_word_cnt;
  assign l1.l1_wr_addr   = r_wr_addr;
  assign l1.l1_rd_addr   = r_rd_addr;
  assign l1.l1_empty     = w_empty;
  assign l1.l1_full      = w_full;
  assign l1.l1_first_evt = r_first_evt;

  tdc_pattern_lfsr u_tdc (
    .clk           (clk),
    .rst           (reset),
    .i_dis         (tdc_dis),
    .i_mode        (tdc_mode),
    .i_latency_l1a (latency_l1a),
    .i_pixel_id    (pixel_id),
    .i_occupancy   (occupancy),
    .o_tdc_word    (w_tdc_word)
  );

  assign tdc_data = w_tdc_word;

endmodule
`default_nettype wire

// File: tb/tb_readout_addr_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_readout_addr_pattern_gen
// Purpose : Self-checking bench for readout_addr_pattern_gen.
// Rev     : 1.0  initial release
// ============================================================================
module tb_readout_addr_pattern_gen;
  import readout_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  cb_wr_addr;
  logic        tdc_dis;
  logic        tdc_mode;
  logic [8:0]  latency_l1a;
  logic [7:0]  pixel_id;
  logic [6:0]  occupancy;
  logic [29:0] tdc_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  readout_addr_pattern_gen_if #(.L1_AW(7)) l1_if ();

  readout_addr_pattern_gen dut (
    .clk         (clk),
    .reset       (reset),
    .cb_wr_addr  (cb_wr_addr),
    .l1          (l1_if),
    .tdc_dis     (tdc_dis),
    .tdc_mode    (tdc_mode),
    .latency_l1a (latency_l1a),
    .pixel_id    (pixel_id),
    .occupancy   (occupancy),
    .tdc_data    (tdc_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference model: cycle-level arithmetic from the block's rules
  int          m_cb, m_wp, m_rp, m_cnt;
  bit          m_fe;
  bit [31:0]   m_lfsr;
  bit [9:0]    m_tc;
  bit [29:0]   m_tdc;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    bit push, pop, fb;
    if (reset) begin
      m_cb = 0; m_wp = 0; m_rp = 0; m_cnt = 0; m_fe = 1'b0;
      m_lfsr = {pixel_id, 6'b0, latency_l1a, 9'h001};
      m_tc = '0; m_tdc = '0;
    end else begin
      m_cb = (m_cb + 1) % 512;
      push = l1_if.l1_wr_en && (m_cnt != 127);
      pop  = l1_if.l1_rd_en && (m_cnt != 0);
      m_fe = push && (m_cnt == 0);
      if (push) begin m_wp = (m_wp + 1) % 128; m_cnt = m_cnt + 1; end
      if (pop)  begin m_rp = (m_rp + 1) % 128; m_cnt = m_cnt - 1; end
      if (!tdc_dis) begin
        if (int'(m_lfsr[6:0]) < int'(occupancy)) begin
          if (tdc_mode) m_tdc = {m_lfsr[31:22], m_lfsr[21:13], m_lfsr[16:7], 1'b1};
          else          m_tdc = {m_tc, m_tc[8:0], pixel_id, 2'b00, 1'b1};
        end else begin
          m_tdc = '0;
        end
        fb = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0];
        m_lfsr = {m_lfsr[30:0], fb};
        m_tc = m_tc + 10'd1;
      end else begin
        m_tdc = '0;
      end
    end
    m_valid = 1'b1;
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_cb",    32'(cb_wr_addr),         32'(m_cb));
      chk("m_wp",    32'(l1_if.l1_wr_addr),   32'(m_wp));
      chk("m_rp",    32'(l1_if.l1_rd_addr),   32'(m_rp));
      chk("m_cnt",   32'(l1_if.l1_word_cnt),  32'(m_cnt));
      chk("m_empty", 32'(l1_if.l1_empty),     32'(m_cnt == 0));
      chk("m_full",  32'(l1_if.l1_full),      32'(m_cnt == 127));
      chk("m_fe",    32'(l1_if.l1_first_evt), 32'(m_fe));
      chk("m_tdc",   32'(tdc_data),           32'(m_tdc));
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int hits;
    logic [29:0] prev;
    reset = 1'b1; l1_if.l1_wr_en = 1'b0; l1_if.l1_rd_en = 1'b0;
    tdc_dis = 1'b0; tdc_mode = 1'b1; latency_l1a = 9'h0A5; pixel_id = 8'h3C; occupancy = 7'd64;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_cb",    32'(cb_wr_addr), 32'd0);
    chk("rst_empty", 32'(l1_if.l1_empty), 32'd1);
    chk("rst_full",  32'(l1_if.l1_full), 32'd0);
    chk("rst_cnt",   32'(l1_if.l1_word_cnt), 32'd0);
    chk("rst_tdc",   32'(tdc_data), 32'd0);

    // CB address sweep through the wrap
    for (int i = 1; i < 520; i++) begin
      @(negedge clk);
      chk("cb_step", 32'(cb_wr_addr), 32'(i % 512));
    end

    // Single push into empty, then pop
    l1_if.l1_wr_en = 1'b1;
    @(negedge clk); l1_if.l1_wr_en = 1'b0;
    chk("push1_cnt",   32'(l1_if.l1_word_cnt), 32'd1);
    chk("push1_empty", 32'(l1_if.l1_empty), 32'd0);
    chk("push1_fe",    32'(l1_if.l1_first_evt), 32'd1);
    @(negedge clk);
    chk("fe_pulse", 32'(l1_if.l1_first_evt), 32'd0);
    l1_if.l1_rd_en = 1'b1;
    @(negedge clk); l1_if.l1_rd_en = 1'b0;
    chk("pop1_cnt", 32'(l1_if.l1_word_cnt), 32'd0);
    chk("pop1_rd",  32'(l1_if.l1_rd_addr), 32'd1);

    // Fill past full
    do_reset();
    l1_if.l1_wr_en = 1'b1;
    repeat (130) @(negedge clk);
    chk("fill_full", 32'(l1_if.l1_full), 32'd1);
    chk("fill_cnt",  32'(l1_if.l1_word_cnt), 32'd127);
    chk("fill_wr",   32'(l1_if.l1_wr_addr), 32'd127);
    l1_if.l1_rd_en = 1'b1;
    @(negedge clk); l1_if.l1_wr_en = 1'b0; l1_if.l1_rd_en = 1'b0;
    chk("full_pp_cnt", 32'(l1_if.l1_word_cnt), 32'd126);
    chk("full_pp_wr",  32'(l1_if.l1_wr_addr), 32'd127);

    // Simultaneous push/pop at count 5, then pop past empty
    do_reset();
    l1_if.l1_wr_en = 1'b1;
    repeat (5) @(negedge clk);
    l1_if.l1_rd_en = 1'b1;
    @(negedge clk); l1_if.l1_wr_en = 1'b0;
    chk("pp_cnt", 32'(l1_if.l1_word_cnt), 32'd5);
    chk("pp_wr",  32'(l1_if.l1_wr_addr), 32'd6);
    chk("pp_rd",  32'(l1_if.l1_rd_addr), 32'd1);
    repeat (6) @(negedge clk); l1_if.l1_rd_en = 1'b0;
    chk("drain_cnt", 32'(l1_if.l1_word_cnt), 32'd0);
    chk("drain_rd",  32'(l1_if.l1_rd_addr), 32'd6);

    // Hit-rate statistics in random mode
    occupancy = 7'd0; @(negedge clk);
    hits = 0;
    for (int i = 0; i < 10000; i++) begin @(negedge clk); hits += int'(tdc_data[0]); end
    chk_range("hits_occ0", hits, 0, 0);
    occupancy = 7'd127; @(negedge clk);
    hits = 0;
    for (int i = 0; i < 10000; i++) begin @(negedge clk); hits += int'(tdc_data[0]); end
    chk_range("hits_occ127", hits, 9800, 10000);
    occupancy = 7'd64; @(negedge clk);
    hits = 0;
    for (int i = 0; i < 10000; i++) begin @(negedge clk); hits += int'(tdc_data[0]); end
    chk_range("hits_occ64", hits, 4800, 5200);

    // Counter mode, Cal field and disable/resume
    pixel_id = 8'h15; tdc_mode = 1'b0; occupancy = 7'd127;
    do_reset();
    hits = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tdc_data[0]) begin
        hits++;
        chk("cal_mode0", 32'(tdc_data[10:1]), 32'h054);
      end
    end
    chk_range("mode0_hits", hits, 1, 50);
    prev = tdc_data;
    tdc_dis = 1'b1;
    @(negedge clk);
    chk("dis_zero", 32'(tdc_data), 32'd0);
    @(negedge clk);
    tdc_dis = 1'b0;
    @(negedge clk);
    if (prev[0] && tdc_data[0])
      chk("resume_toa", 32'(tdc_data[29:20]), 32'(10'(prev[29:20] + 10'd1)));
    tdc_mode = 1'b1;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
